// File: rtl/kabeta_intr_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kabeta_intr_ctrl_pkg                                                 |
// | Register offsets and FSM encoding shared by the interrupt controller |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package kabeta_intr_ctrl_pkg;

  localparam logic [2:0] EIC_REG_MASK = 3'd0;
  localparam logic [2:0] EIC_REG_PEND = 3'd1;
  localparam logic [2:0] EIC_REG_MODE = 3'd2;
  localparam logic [2:0] EIC_REG_STAT = 3'd3;
  localparam logic [2:0] EIC_REG_EOI  = 3'd4;

  typedef enum logic [1:0] {
    EIC_IDLE = 2'd0,
    EIC_REQ  = 2'd1,
    EIC_SERV = 2'd2
  } eic_state_t;

endpackage
`default_nettype wire

// File: rtl/kabeta_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kabeta_sync2                                                         |
// | Parametrised-width two-flop synchroniser with asynchronous reset     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module kabeta_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/kabeta_intr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kabeta_intr_ctrl                                                     |
// | External interrupt controller: sync, latch, mask, prioritise, Req/Ack|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module kabeta_intr_ctrl
  import kabeta_intr_ctrl_pkg::*;
#(
  parameter int          NUM_CH     = 8,
  parameter int          ID_W       = 3,
  parameter logic [29:0] BASE_WADDR = 30'h0,
  parameter logic [31:0] MODE_RST   = 32'h0
) (
  input  logic              Sys_Clock,
  input  logic              Sys_Reset,
  input  logic [NUM_CH-1:0] Irq_Src,
  output logic              EIC_I_Req,
  output logic [ID_W-1:0]   EIC_I_Id,
  input  logic              EIC_I_Ack,
  input  logic              IO_EnR,
  input  logic              IO_EnW,
  input  logic [29:0]       IO_Address,
  input  logic [31:0]       IO_DataW,
  output logic [31:0]       IO_DataR
);

  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_sync_d;
  eic_state_t        r_state;
  logic              r_req;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_isr_id;
  logic [31:0]       r_rdata;

  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_edge_set;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_pend_nxt;
  logic [NUM_CH-1:0] w_elig;
  logic              w_hit;
  logic [2:0]        w_off;
  logic              w_wr_mask;
  logic              w_wr_pend;
  logic              w_wr_mode;
  logic              w_wr_eoi;
  logic              w_ack_fire;
  logic [31:0]       w_rd;
  logic              w_unused;

  // Lowest channel index wins.
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_CH-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  kabeta_sync2 #(
    .WIDTH (NUM_CH)
  ) u_sync (
    .clk (Sys_Clock),
    .rst (Sys_Reset),
    .i_d (Irq_Src),
    .o_q (w_sync)
  );

  assign w_hit      = (IO_Address[29:3] == BASE_WADDR[29:3]);
  assign w_off      = IO_Address[2:0];
  assign w_wr_mask  = IO_EnW && w_hit && (w_off == EIC_REG_MASK);
  assign w_wr_pend  = IO_EnW && w_hit && (w_off == EIC_REG_PEND);
  assign w_wr_mode  = IO_EnW && w_hit && (w_off == EIC_REG_MODE);
  assign w_wr_eoi   = IO_EnW && w_hit && (w_off == EIC_REG_EOI);
  assign w_ack_fire = (r_state == EIC_REQ) && EIC_I_Ack;
  assign w_elig     = r_pend & r_mask;
  assign w_edge_set = w_sync & ~r_sync_d;
  assign w_unused   = ^IO_DataW;

  // Edge channels: a fresh edge beats any clear in the same cycle; level channels follow the source.
  always_comb begin
    w_clr = '0;
    if (w_wr_pend)  w_clr = w_clr | IO_DataW[NUM_CH-1:0];
    if (w_ack_fire) w_clr = w_clr | (NUM_CH'(1) << r_id);
    w_pend_nxt = (r_mode & (w_edge_set | (r_pend & ~w_clr))) | (~r_mode & w_sync);
  end

  always_comb begin
    w_rd = '0;
    case (w_off)
      EIC_REG_MASK: w_rd = 32'(r_mask);
      EIC_REG_PEND: w_rd = 32'(r_pend);
      EIC_REG_MODE: w_rd = 32'(r_mode);
      EIC_REG_STAT: w_rd = {r_state, 30'(r_isr_id)};
      default:      w_rd = '0;
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_mask   <= '0;
      r_mode   <= MODE_RST[NUM_CH-1:0];
      r_pend   <= '0;
      r_sync_d <= '0;
      r_rdata  <= '0;
    end else begin
      r_sync_d <= w_sync;
      r_pend   <= w_pend_nxt;
      if (w_wr_mask) r_mask <= IO_DataW[NUM_CH-1:0];
      if (w_wr_mode) r_mode <= IO_DataW[NUM_CH-1:0];
      if (IO_EnR && w_hit) r_rdata <= w_rd;
    end
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_state  <= EIC_IDLE;
      r_req    <= 1'b0;
      r_id     <= '0;
      r_isr_id <= '0;
    end else begin
      case (r_state)
        EIC_IDLE: begin
          if (|w_elig) begin
            r_state <= EIC_REQ;
            r_req   <= 1'b1;
            r_id    <= prio_enc(w_elig);
          end
        end
        EIC_REQ: begin
          if (EIC_I_Ack) begin
            r_state  <= EIC_SERV;
            r_req    <= 1'b0;
            r_isr_id <= r_id;
          end
        end
        EIC_SERV: begin
          if (w_wr_eoi) r_state <= EIC_IDLE;
        end
        default: begin
          r_state <= EIC_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign EIC_I_Req = r_req;
  assign EIC_I_Id  = r_id;
  assign IO_DataR  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_kabeta_intr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_kabeta_intr_ctrl                                                  |
// | Directed self-checking bench for kabeta_intr_ctrl                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_kabeta_intr_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic        req;
  logic [2:0]  id;
  logic        ack;
  logic        en_r;
  logic        en_w;
  logic [29:0] addr;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic [31:0] rd;

  int n_pass  = 0;
  int n_total = 0;

  kabeta_intr_ctrl #(
    .NUM_CH     (8),
    .ID_W       (3),
    .BASE_WADDR (30'h0),
    .MODE_RST   (32'h0)
  ) dut (
    .Sys_Clock  (clk),
    .Sys_Reset  (rst),
    .Irq_Src    (irq_src),
    .EIC_I_Req  (req),
    .EIC_I_Id   (id),
    .EIC_I_Ack  (ack),
    .IO_EnR     (en_r),
    .IO_EnW     (en_w),
    .IO_Address (addr),
    .IO_DataW   (data_w),
    .IO_DataR   (data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic io_write(input logic [2:0] off, input logic [31:0] d);
    addr   = {27'd0, off};
    data_w = d;
    en_w   = 1'b1;
    tick();
    en_w   = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] off, output logic [31:0] d);
    addr = {27'd0, off};
    en_r = 1'b1;
    tick();
    en_r = 1'b0;
    d    = data_r;
  endtask

  task automatic pulse_src(input logic [7:0] bits);
    irq_src = bits;
    tick();
    irq_src = 8'h00;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; ack = 1'b0; en_r = 1'b0; en_w = 1'b0;
    addr = '0; data_w = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_id", {29'd0, id}, 32'd0);
    check("rst_datar", data_r, 32'd0);
    io_read(3'd0, rd); check("rst_mask", rd, 32'h0);
    io_read(3'd2, rd); check("rst_mode", rd, 32'h0);

    // Edge pulse on ch5: Req at edge 4 after the rise
    io_write(3'd0, 32'hFF);
    io_write(3'd2, 32'hFF);
    pulse_src(8'h20);            // edge 1
    tick();                      // edge 2
    tick();                      // edge 3
    check("lat_req_e3", {31'd0, req}, 32'd0);
    tick();                      // edge 4
    check("lat_req_e4", {31'd0, req}, 32'd1);
    check("lat_id5", {29'd0, id}, 32'd5);
    io_read(3'd1, rd); check("pend5_req", rd, 32'h20);
    do_ack();
    check("ack_req0", {31'd0, req}, 32'd0);
    io_read(3'd1, rd); check("pend5_clr", rd, 32'h0);
    io_read(3'd3, rd); check("stat_serv5", rd, 32'h8000_0005);
    io_write(3'd4, 32'h0);
    io_read(3'd3, rd); check("stat_idle", rd >> 30, 32'd0);
    io_write(3'd5, 32'hFFFF_FFFF);
    io_read(3'd5, rd); check("off5_zero", rd, 32'h0);

    // Channels 2 and 6 pending together
    pulse_src(8'h44);
    repeat (3) tick();
    check("pri_req", {31'd0, req}, 32'd1);
    check("pri_id2", {29'd0, id}, 32'd2);
    do_ack();
    io_read(3'd1, rd); check("pend6_left", rd, 32'h40);
    io_write(3'd4, 32'h0);
    check("eoi_req0", {31'd0, req}, 32'd0);
    tick();
    check("rearb_req", {31'd0, req}, 32'd1);
    check("rearb_id6", {29'd0, id}, 32'd6);
    do_ack();
    io_write(3'd4, 32'h0);

    // Masked source stays pending until unmasked
    io_write(3'd0, 32'h00);
    pulse_src(8'h08);
    repeat (3) tick();
    tick();
    check("masked_noreq", {31'd0, req}, 32'd0);
    io_read(3'd1, rd); check("masked_pend3", rd, 32'h08);
    io_write(3'd0, 32'h08);
    check("unmask_req_e1", {31'd0, req}, 32'd0);
    tick();
    check("unmask_req_e2", {31'd0, req}, 32'd1);
    check("unmask_id3", {29'd0, id}, 32'd3);
    do_ack();
    io_write(3'd4, 32'h0);

    // Level channel 1
    io_write(3'd2, 32'hFD);
    io_write(3'd0, 32'hFF);
    irq_src = 8'h02;
    repeat (4) tick();
    check("lvl_req", {31'd0, req}, 32'd1);
    check("lvl_id1", {29'd0, id}, 32'd1);
    do_ack();
    io_read(3'd1, rd); check("lvl_pend_kept", rd, 32'h02);
    io_write(3'd4, 32'h0);
    tick();
    check("lvl_rereq", {31'd0, req}, 32'd1);
    check("lvl_reid1", {29'd0, id}, 32'd1);
    io_write(3'd1, 32'h02);
    io_read(3'd1, rd); check("lvl_w1c_ign", rd, 32'h02);
    irq_src = 8'h00;
    repeat (3) tick();
    io_read(3'd1, rd); check("lvl_drop", rd, 32'h00);
    do_ack();
    io_write(3'd4, 32'h0);
    io_write(3'd2, 32'hFF);

    // Req/Id hold in REQ; new edge during the Ack cycle survives
    pulse_src(8'h10);
    repeat (3) tick();
    check("hold_req", {31'd0, req}, 32'd1);
    check("hold_id4", {29'd0, id}, 32'd4);
    io_write(3'd0, 32'h00);
    check("hold_req_m0", {31'd0, req}, 32'd1);
    check("hold_id_m0", {29'd0, id}, 32'd4);
    pulse_src(8'h10);
    tick();
    do_ack();
    check("ackedge_req0", {31'd0, req}, 32'd0);
    io_read(3'd1, rd); check("ackedge_pend4", rd, 32'h10);
    io_read(3'd3, rd); check("stat_serv4", rd, 32'h8000_0004);
    io_write(3'd4, 32'h0);
    tick();
    check("masked_after_eoi", {31'd0, req}, 32'd0);
    io_write(3'd1, 32'h10);
    io_read(3'd1, rd); check("edge_w1c", rd, 32'h00);

    // Asynchronous reset during service
    io_write(3'd0, 32'hFF);
    pulse_src(8'h80);
    repeat (3) tick();
    check("pre_rst_id7", {29'd0, id}, 32'd7);
    do_ack();
    io_read(3'd0, rd); check("pre_rst_mask", rd, 32'hFF);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, req}, 32'd0);
    check("arst_id", {29'd0, id}, 32'd0);
    check("arst_datar", data_r, 32'd0);
    tick();
    rst = 1'b0;
    io_read(3'd0, rd); check("arst_mask", rd, 32'h0);
    io_read(3'd3, rd); check("arst_stat", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
